// File: rtl/fp16_iterative_divider.sv
// fp16_iterative_divider: sequential IEEE-754 half-precision divider (a / b), one quotient bit per cycle, fixed 16-edge latency
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   start  : request, sampled only in IDLE; a and b are captured on the accepting edge
//   busy   : high from the accepted start until the done edge
//   done   : one-cycle pulse, result valid from this cycle
//   result : quotient, held until the next done
module fp16_iterative_divider #(
   parameter int DATA_WIDTH = 16,
   parameter int EXP_WIDTH  = 5,
   parameter int MANT_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);
   typedef enum logic [1:0] {IDLE, DIV, ROUND} state_t;
   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [11:0] r_q, r_d;
   logic [14:0] q_q, q_d;
   logic done_q, done_d;
   logic sa, sb, s;
   logic [EXP_WIDTH-1:0] ea, eb;
   logic [MANT_WIDTH-1:0] fa, fb;
   logic za, zb, ia, ib, na, nb;
   logic ge;
   logic [11:0] r_sub;
   logic norm, guard, sticky, inc;
   logic [9:0] mant_t;
   logic [10:0] mant_r;
   logic signed [6:0] e0, e_f;
   logic [15:0] special, normal, final_res;
   logic is_nan, is_inf, is_zero;
   assign sa = a_q[DATA_WIDTH-1];
   assign sb = b_q[DATA_WIDTH-1];
   assign ea = a_q[DATA_WIDTH-2 -: EXP_WIDTH];
   assign eb = b_q[DATA_WIDTH-2 -: EXP_WIDTH];
   assign fa = a_q[MANT_WIDTH-1:0];
   assign fb = b_q[MANT_WIDTH-1:0];
   assign s  = sa ^ sb;
   // exp=0 is flushed to zero, so subnormal operands never reach the mantissa path
   assign za = ea == '0;
   assign zb = eb == '0;
   assign ia = &ea && fa == '0;
   assign ib = &eb && fb == '0;
   assign na = &ea && fa != '0;
   assign nb = &eb && fb != '0;
   // restoring step: r stays below 2*mb, so 12 bits always suffice
   assign ge    = r_q >= {1'b0, 1'b1, fb};
   assign r_sub = ge ? r_q - {1'b0, 1'b1, fb} : r_q;
   assign norm   = q_q[14];
   assign mant_t = norm ? q_q[13:4] : q_q[12:3];
   assign guard  = norm ? q_q[3] : q_q[2];
   assign sticky = (norm ? |q_q[2:0] : |q_q[1:0]) | (|r_q);
   assign inc    = guard & (sticky | mant_t[0]);
   assign mant_r = {1'b0, mant_t} + {10'd0, inc};
   assign e0  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + (norm ? 7'sd15 : 7'sd14);
   assign e_f = e0 + $signed({6'd0, mant_r[10]});
   assign normal = e_f >= 7'sd31 ? {s, 5'h1F, 10'h000} :
                   e_f <= 7'sd0  ? {s, 15'h0000} : {s, e_f[4:0], mant_r[9:0]};
   assign is_nan  = na | nb | (za & zb) | (ia & ib);
   assign is_inf  = ia | zb;
   assign is_zero = za | ib;
   assign special = is_nan ? 16'h7E00 : is_inf ? {s, 5'h1F, 10'h000} : {s, 15'h0000};
   assign final_res = (is_nan | is_inf | is_zero) ? special : normal;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      q_d     = q_q;
      res_d   = res_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = DIV;
            cnt_d   = '0;
            a_d     = a;
            b_d     = b;
            r_d     = {2'b01, a[MANT_WIDTH-1:0]};
            q_d     = '0;
         end
         DIV: begin
            q_d     = {q_q[13:0], ge};
            r_d     = {r_sub[10:0], 1'b0};
            cnt_d   = cnt_q + 4'd1;
            state_d = cnt_q == 4'd14 ? ROUND : DIV;
         end
         ROUND: begin
            res_d   = final_res;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         q_q     <= '0;
         res_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         q_q     <= q_d;
         res_q   <= res_d;
         done_q  <= done_d;
      end
   end
   assign busy   = state_q != IDLE;
   assign done   = done_q;
   assign result = res_q;
endmodule
